sync_fifo_core: RTL and testbench

//   Single-clock first-in/first-out buffer between a producer and a consumer in the same clock domain.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_mem.sv | 24 ++
 rtl/sync_fifo_core.sv | 74 +++++++
 tb/tb_sync_fifo_core.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, pointer type and depth sanity check for the synchronous FIFO.
package fifo_pkg;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 16;
    localparam int FIFO_ADDR_WIDTH = $clog2(FIFO_DEPTH);

    // Extra MSB is the wrap bit that separates full from empty.
    typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read, no reset.
// Read data follows raddr combinationally; the caller registers it.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO, 1-cycle registered read; writes dropped when full, reads ignored when empty.
// Optional occupancy output fifo_count is enabled by defining FIFO_LEVEL_EN.
module sync_fifo_core
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    fifo_full,
    output logic                    fifo_empty
`ifdef FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]  fifo_count
`endif
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_core: DEPTH must be a power of two and at least 2");
    end

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                        (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    // Full and empty are mutually exclusive, so an accepted read and write never hit the same slot.
    assign wr_acc = wr_en && !fifo_full && !rst;
    assign rd_acc = rd_en && !fifo_empty;

`ifdef FIFO_LEVEL_EN
    assign fifo_count = wr_ptr - rd_ptr;
`endif

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_out <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                data_out <= mem_rdata;
                rd_ptr   <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo_core.sv
// Randomised and directed checks of sync_fifo_core against a queue-based reference model.
module tb_sync_fifo_core;
    import fifo_pkg::*;

    localparam int DW = FIFO_DATA_WIDTH;
    localparam int DP = FIFO_DEPTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          fifo_full;
    logic          fifo_empty;
`ifdef FIFO_LEVEL_EN
    logic [FIFO_ADDR_WIDTH:0] fifo_count;
`endif

    sync_fifo_core #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .data_in    (data_in),
        .data_out   (data_out),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
`ifdef FIFO_LEVEL_EN
        ,
        .fifo_count (fifo_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_dout = '0;
    ptr_t          wr_pos = '0;   // accepted writes since reset, modulo 2*DEPTH

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".dout"},  data_out,   model_dout);
        check({tag, ".empty"}, fifo_empty, model_q.size() == 0);
        check({tag, ".full"},  fifo_full,  model_q.size() == DP);
`ifdef FIFO_LEVEL_EN
        check({tag, ".count"}, fifo_count, model_q.size());
`endif
    endtask

    // Called at posedge+1; applies one cycle of stimulus and checks the result at the next posedge+1.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input string tag);
        bit was_full;
        bit was_empty;
        was_full  = (model_q.size() == DP);
        was_empty = (model_q.size() == 0);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        if (r && !was_empty) model_dout = model_q.pop_front();
        if (w && !was_full) begin
            model_q.push_back(d);
            wr_pos = wr_pos + 1'b1;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_outputs(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        model_dout = '0;
        wr_pos = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two clocks.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // Fill, then one dropped write while full.
        for (int i = 1; i <= DP; i++) step(1'b1, 1'b0, DW'(i), "fill");
        step(1'b1, 1'b0, 8'hFF, "fill_drop");

        // Drain in order, then a refused read must hold the last word.
        for (int i = 1; i <= DP; i++) begin
            step(1'b0, 1'b1, '0, "drain");
            check("drain_val", data_out, i);
        end
        step(1'b0, 1'b1, '0, "rd_empty");
        check("rd_empty_hold", data_out, 8'h10);

        // Write+read while empty: only the write lands.
        step(1'b1, 1'b1, 8'h5A, "wr_rd_empty");

        // Build 4 entries, then position the write pointer just before the wrap point.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'($urandom), "conc_fill");
        for (int i = 0; i < 64 && wr_pos != ptr_t'(2*DP - 3); i++)
            step(1'b1, 1'b1, DW'($urandom), "conc_pos");
        check("conc_pos_reached", wr_pos, 2*DP - 3);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, DW'($urandom), "conc_wrap");
            check("conc_occ", 32'(model_q.size()), 4);
        end

        // Write+read while full: oldest word out, write refused, full drops.
        while (model_q.size() < DP) step(1'b1, 1'b0, DW'($urandom), "refill");
        step(1'b1, 1'b1, 8'hAA, "wr_rd_full");

        // Random traffic with varying bias.
        for (int i = 0; i < 600; i++) begin
            int unsigned bias;
            bias = (i / 150) % 2 == 0 ? 70 : 30;
            step($urandom_range(99) < bias, $urandom_range(99) < 100 - bias,
                 DW'($urandom), "random");
        end

        // Mid-cycle asynchronous reset with 7 entries stored.
        while (model_q.size() > 7) step(1'b0, 1'b1, '0, "to7_rd");
        while (model_q.size() < 7) step(1'b1, 1'b0, DW'($urandom), "to7_wr");
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_empty", fifo_empty, 1);
        check("arst_full",  fifo_full,  0);
        check("arst_dout",  data_out,   0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("arst_hold");

        // Restart from address 0.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'hC0 + i), "post_wr");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, '0, "post_rd");
            check("post_val", data_out, 8'hC0 + i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
